// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared types and helpers for the time-multiplexed FIR tap sequencer.
//   - fir_state_e : sequencer states (IDLE / MAC / HOLD)
//   - ptr_width   : width of a tap index / delay-line pointer
//   - cnt_width   : width of a counter that must also hold NUM_TAPS itself
//   - acc_width   : accumulator width that cannot overflow over all taps
//   - round_const : half-LSB constant added before the output shift
//   - saturate    : clamp a wide signed value into a DATA_WIDTH range
// The arithmetic helpers work on 64-bit signed values, so the accumulator
// width (DATA_WIDTH + COEFF_WIDTH + $clog2(NUM_TAPS)) must stay below 64.
// -----------------------------------------------------------------------------
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    HOLD = 2'd2
  } fir_state_e;

  function automatic int ptr_width(input int num_taps);
    return (num_taps > 1) ? $clog2(num_taps) : 1;
  endfunction

  function automatic int cnt_width(input int num_taps);
    return $clog2(num_taps + 1);
  endfunction

  function automatic int acc_width(input int data_width, input int coeff_width,
                                   input int num_taps);
    return data_width + coeff_width + $clog2(num_taps);
  endfunction

  function automatic logic signed [63:0] round_const(input int coeff_width);
    return 64'sd1 <<< (coeff_width - 2);
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                  input int data_width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (data_width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_width - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// -----------------------------------------------------------------------------
// fir_tap_sequencer_if
// Bundles the sample input handshake, the coefficient configuration port and
// the sample output handshake of the FIR tap sequencer.
//   master : sample source / software / consumer side (drives in_*, cfg_*,
//            out_ready; observes in_ready, cfg_pending, out_valid, out_data)
//   slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface fir_tap_sequencer_if
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int NUM_TAPS    = 32
);

  localparam int PTR_WIDTH = ptr_width(NUM_TAPS);

  logic                          in_valid;
  logic                          in_ready;
  logic signed [DATA_WIDTH-1:0]  in_data;

  logic                          cfg_we;
  logic        [PTR_WIDTH-1:0]   cfg_addr;
  logic signed [COEFF_WIDTH-1:0] cfg_data;
  logic                          cfg_commit;
  logic                          cfg_pending;

  logic                          out_valid;
  logic                          out_ready;
  logic signed [DATA_WIDTH-1:0]  out_data;

  modport master (
    output in_valid, in_data,
    output cfg_we, cfg_addr, cfg_data, cfg_commit,
    output out_ready,
    input  in_ready, cfg_pending, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data,
    input  cfg_we, cfg_addr, cfg_data, cfg_commit,
    input  out_ready,
    output in_ready, cfg_pending, out_valid, out_data
  );

endinterface

// File: rtl/fir_mac_unit.sv
// -----------------------------------------------------------------------------
// fir_mac_unit
// Single signed multiply-accumulate lane plus the output conditioning stage.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear_i   : zero the accumulator on the next edge (wins over en_i)
//   en_i      : add sample_i * coeff_i into the accumulator on the next edge
//   sample_i  : signed delay-line sample
//   coeff_i   : signed coefficient
//   result_o  : accumulator rounded half-up, shifted by COEFF_WIDTH-1 and
//               saturated to DATA_WIDTH (combinational from the accumulator)
// -----------------------------------------------------------------------------
module fir_mac_unit
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int NUM_TAPS    = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear_i,
  input  logic                          en_i,
  input  logic signed [DATA_WIDTH-1:0]  sample_i,
  input  logic signed [COEFF_WIDTH-1:0] coeff_i,
  output logic signed [DATA_WIDTH-1:0]  result_o
);

  localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, COEFF_WIDTH, NUM_TAPS);
  localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;

  logic signed [PROD_WIDTH-1:0] product_s;
  logic signed [ACC_WIDTH-1:0]  acc_q;
  logic signed [ACC_WIDTH-1:0]  acc_d;
  logic signed [63:0]           acc_ext_s;
  logic signed [63:0]           rounded_s;

  // Full-precision signed product; both operands sign-extended first.
  assign product_s = PROD_WIDTH'(sample_i) * PROD_WIDTH'(coeff_i);

  // Accumulator next-state: clear at sample start, add one tap per enable.
  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_WIDTH'(product_s);
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Output stage: add half an output LSB, arithmetic shift, then clamp.
  // The arithmetic shift floors, so the added half gives round-half-up.
  always_comb begin
    acc_ext_s = 64'(acc_q);
    rounded_s = (acc_ext_s + round_const(COEFF_WIDTH)) >>> (COEFF_WIDTH - 1);
    result_o  = DATA_WIDTH'(saturate(rounded_s, DATA_WIDTH));
  end

endmodule

// File: rtl/fir_tap_sequencer.sv
// -----------------------------------------------------------------------------
// fir_tap_sequencer
// Time-multiplexed FIR controller. Accepts one sample per input handshake into
// a circular delay line, walks one multiply-accumulate across all NUM_TAPS
// taps, and presents one rounded, saturated output sample held until the
// consumer takes it. Coefficients are double-buffered: software writes the
// shadow bank and commits; the swap happens on the next sample-accept edge so
// every sample sees exactly one coefficient set.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset (discards any in-flight sample)
//   bus  : fir_tap_sequencer_if.slave
//          in_valid/in_ready/in_data        sample input handshake
//          cfg_we/cfg_addr/cfg_data         shadow-bank coefficient write
//          cfg_commit/cfg_pending           bank swap request / status
//          out_valid/out_ready/out_data     sample output handshake
// Timing (accept edge = 0): taps accumulate on edges 1..NUM_TAPS, the output
// is registered on edge NUM_TAPS+1, in_ready returns the cycle after the
// output handshake.
// -----------------------------------------------------------------------------
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int NUM_TAPS    = 32
) (
  input logic                 clk,
  input logic                 rst,
  fir_tap_sequencer_if.slave  bus
);

  localparam int PTR_WIDTH = ptr_width(NUM_TAPS);
  localparam int CNT_WIDTH = cnt_width(NUM_TAPS);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_TAPS);
  localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(NUM_TAPS - 1);
  // NUM_TAPS reduced modulo 2^PTR_WIDTH; used for the wrap-around read
  // address, which is correct for any NUM_TAPS since the true result < NUM_TAPS.
  localparam logic [PTR_WIDTH-1:0] NT_MOD   = PTR_WIDTH'(NUM_TAPS);
  localparam logic [PTR_WIDTH:0]   NT_WIDE  = (PTR_WIDTH + 1)'(NUM_TAPS);

  fir_state_e                    state_q;
  fir_state_e                    state_d;
  logic        [PTR_WIDTH-1:0]   wr_ptr_q;
  logic        [PTR_WIDTH-1:0]   wr_ptr_d;
  logic        [CNT_WIDTH-1:0]   tap_cnt_q;
  logic        [CNT_WIDTH-1:0]   tap_cnt_d;
  logic                          out_valid_q;
  logic                          out_valid_d;
  logic signed [DATA_WIDTH-1:0]  out_data_q;
  logic signed [DATA_WIDTH-1:0]  out_data_d;
  logic                          pending_q;
  logic                          pending_d;
  logic                          bank_sel_q;
  logic                          bank_sel_d;

  logic signed [DATA_WIDTH-1:0]  line_q [NUM_TAPS];
  logic signed [COEFF_WIDTH-1:0] bank_q [2][NUM_TAPS];

  logic                          in_ready_s;
  logic                          accept_s;
  logic                          swap_s;
  logic                          cfg_wr_s;
  logic                          shadow_sel_s;
  logic        [PTR_WIDTH-1:0]   tap_idx_s;
  logic        [PTR_WIDTH-1:0]   rd_ptr_s;
  logic signed [DATA_WIDTH-1:0]  sample_s;
  logic signed [COEFF_WIDTH-1:0] coeff_s;
  logic                          mac_clear_s;
  logic                          mac_en_s;
  logic signed [DATA_WIDTH-1:0]  mac_result_s;

  // Handshake qualifiers; in_ready is forced low while reset is asserted.
  always_comb begin
    in_ready_s   = (state_q == IDLE) && !rst;
    accept_s     = bus.in_valid && in_ready_s;
    // A commit arriving on the accept edge itself still applies to this sample.
    swap_s       = accept_s && (pending_q || bus.cfg_commit);
    shadow_sel_s = ~bank_sel_q;
    cfg_wr_s     = bus.cfg_we && ({1'b0, bus.cfg_addr} < NT_WIDE);
  end

  // Tap address generation: tap k reads the sample k steps behind wr_ptr.
  always_comb begin
    tap_idx_s = tap_cnt_q[PTR_WIDTH-1:0];
    if (tap_idx_s <= wr_ptr_q) begin
      rd_ptr_s = wr_ptr_q - tap_idx_s;
    end else begin
      rd_ptr_s = wr_ptr_q + NT_MOD - tap_idx_s;
    end
    sample_s = line_q[rd_ptr_s];
    coeff_s  = bank_q[bank_sel_q][tap_idx_s];
  end

  // Sequencer next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    tap_cnt_d   = tap_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    mac_clear_s = 1'b0;
    mac_en_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d     = MAC;
          tap_cnt_d   = '0;
          mac_clear_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      MAC: begin
        // Counter value NUM_TAPS is the extra cycle that registers the
        // fully accumulated result.
        if (tap_cnt_q == LAST_CNT) begin
          out_data_d  = mac_result_s;
          out_valid_d = 1'b1;
          state_d     = HOLD;
          if (wr_ptr_q == LAST_PTR) begin
            wr_ptr_d = '0;
          end else begin
            wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
          end
        end else begin
          mac_en_s  = 1'b1;
          tap_cnt_d = tap_cnt_q + CNT_WIDTH'(1);
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Commit bookkeeping: pending latches a request until the swap edge.
  always_comb begin
    bank_sel_d = bank_sel_q;
    pending_d  = pending_q;
    if (swap_s) begin
      bank_sel_d = ~bank_sel_q;
      pending_d  = 1'b0;
    end else if (bus.cfg_commit) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      tap_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      pending_q   <= 1'b0;
      bank_sel_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      tap_cnt_q   <= tap_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      pending_q   <= pending_d;
      bank_sel_q  <= bank_sel_d;
    end
  end

  // Circular delay line: new sample lands at wr_ptr on the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        line_q[i] <= '0;
      end
    end else if (accept_s) begin
      line_q[wr_ptr_q] <= bus.in_data;
    end
  end

  // Coefficient banks: writes go to the pre-swap shadow, so a write on the
  // swap edge becomes part of the newly active set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        bank_q[0][i] <= '0;
        bank_q[1][i] <= '0;
      end
    end else if (cfg_wr_s) begin
      bank_q[shadow_sel_s][bus.cfg_addr] <= bus.cfg_data;
    end
  end

  fir_mac_unit #(
    .DATA_WIDTH  (DATA_WIDTH),
    .COEFF_WIDTH (COEFF_WIDTH),
    .NUM_TAPS    (NUM_TAPS)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (mac_clear_s),
    .en_i     (mac_en_s),
    .sample_i (sample_s),
    .coeff_i  (coeff_s),
    .result_o (mac_result_s)
  );

  assign bus.in_ready    = in_ready_s;
  assign bus.cfg_pending = pending_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fir_tap_sequencer
// Self-checking bench for fir_tap_sequencer with NUM_TAPS=4, 16-bit data and
// coefficients. A transaction-level reference model (sample history array,
// active/shadow coefficient arrays, pending flag) predicts each output with
// plain integer arithmetic; vector tables and hand sequences cover the
// impulse, timing, saturation, bank-swap, backpressure and reset cases.
// -----------------------------------------------------------------------------
module tb_fir_tap_sequencer;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int NT = 4;

  typedef struct {
    int din;
    int expv;
    bit chk_en;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // reference model state
  int m_hist [NT];   // m_hist[k] = sample received k samples ago
  int m_act  [NT];
  int m_sh   [NT];
  bit m_pend;

  fir_tap_sequencer_if #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .NUM_TAPS(NT)) bus ();

  fir_tap_sequencer #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .NUM_TAPS(NT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NT; i++) begin
      m_hist[i] = 0;
      m_act[i]  = 0;
      m_sh[i]   = 0;
    end
    m_pend = 1'b0;
  endfunction

  // Predict the output for a newly accepted sample x.
  function automatic int model_accept(input int x);
    int     tmp [NT];
    longint acc;
    longint r;
    longint q;
    if (m_pend) begin
      tmp    = m_act;
      m_act  = m_sh;
      m_sh   = tmp;
      m_pend = 1'b0;
    end
    for (int i = NT - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = x;
    acc = 0;
    for (int k = 0; k < NT; k++) acc += longint'(m_hist[k]) * longint'(m_act[k]);
    r = acc + 16384;
    q = r / 32768;
    if (r < 0 && q * 32768 != r) q = q - 1;   // floor division
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  task automatic write_coeff(input int a, input int d);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 2'(a);
    bus.cfg_data = 16'(d);
    m_sh[a] = d;
    step();
    bus.cfg_we = 1'b0;
  endtask

  task automatic commit();
    bus.cfg_commit = 1'b1;
    m_pend = 1'b1;
    step();
    bus.cfg_commit = 1'b0;
  endtask

  task automatic load_all(input int c0, input int c1, input int c2, input int c3);
    write_coeff(0, c0);
    write_coeff(1, c1);
    write_coeff(2, c2);
    write_coeff(3, c3);
  endtask

  // Offer one sample; optional commit / shadow write on the same edge.
  task automatic accept(input int x, input bit cmt, input bit we, input int a,
                        input int d, output int expv);
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      step();
      n++;
    end
    chk("in_ready_wait", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'(x);
    if (we) begin
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 2'(a);
      bus.cfg_data = 16'(d);
      m_sh[a] = d;
    end
    if (cmt) begin
      bus.cfg_commit = 1'b1;
      m_pend = 1'b1;
    end
    expv = model_accept(x);
    step();
    bus.in_valid   = 1'b0;
    bus.cfg_we     = 1'b0;
    bus.cfg_commit = 1'b0;
  endtask

  // Wait for out_valid, capture out_data, complete the handshake.
  task automatic finish_out(output int y);
    int n;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      step();
      n++;
    end
    chk("out_valid_wait", bus.out_valid, 1);
    y = bus.out_data;
    bus.out_ready = 1'b1;
    step();
  endtask

  task automatic do_sample(input int x, input string name);
    int e;
    int y;
    accept(x, 1'b0, 1'b0, 0, 0, e);
    finish_out(y);
    chk(name, y, e);
  endtask

  initial begin
    vec_t imp_tbl [5];
    vec_t sat_tbl [8];
    int   e;
    int   y;
    int   hold;

    imp_tbl[0] = '{16384, 500,  1'b1};
    imp_tbl[1] = '{0,     1000, 1'b1};
    imp_tbl[2] = '{0,     1500, 1'b1};
    imp_tbl[3] = '{0,     2000, 1'b1};
    imp_tbl[4] = '{0,     0,    1'b1};
    for (int i = 0; i < 4; i++) begin
      sat_tbl[i]     = '{32767,  32767,  (i == 3)};
      sat_tbl[4 + i] = '{-32768, -32768, (i == 3)};
    end

    checks = 0;
    errors = 0;
    model_reset();
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.cfg_we     = 1'b0;
    bus.cfg_addr   = '0;
    bus.cfg_data   = '0;
    bus.cfg_commit = 1'b0;
    bus.out_ready  = 1'b1;

    // ---- reset state ----
    step();
    step();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_cfg_pending", bus.cfg_pending, 0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", bus.in_ready, 1);

    // ---- impulse ----
    load_all(1000, 2000, 3000, 4000);
    commit();
    chk("commit_pending_rise", bus.cfg_pending, 1);
    for (int i = 0; i < 5; i++) begin
      accept(imp_tbl[i].din, 1'b0, 1'b0, 0, 0, e);
      if (i == 0) chk("accept_pending_fall", bus.cfg_pending, 0);
      finish_out(y);
      chk("impulse_model", y, e);
      if (imp_tbl[i].chk_en) chk("impulse_vector", y, imp_tbl[i].expv);
    end

    // ---- latency and handshake ----
    accept(1234, 1'b0, 1'b0, 0, 0, e);
    chk("lat_c0_in_ready", bus.in_ready, 0);
    for (int j = 1; j <= 5; j++) begin
      step();
      chk("lat_in_ready_low", bus.in_ready, 0);
      chk("lat_out_valid", bus.out_valid, (j == 5));
    end
    chk("lat_data", bus.out_data, e);
    step();
    chk("lat_out_valid_clear", bus.out_valid, 0);
    chk("lat_in_ready_back", bus.in_ready, 1);

    // ---- saturation ----
    load_all(32767, 32767, 32767, 32767);
    commit();
    for (int i = 0; i < 8; i++) begin
      accept(sat_tbl[i].din, 1'b0, 1'b0, 0, 0, e);
      finish_out(y);
      chk("sat_model", y, e);
      if (sat_tbl[i].chk_en) chk("sat_vector", y, sat_tbl[i].expv);
    end

    // ---- bank swap during MAC ----
    load_all(8192, 8192, 8192, 8192);
    commit();
    do_sample(3000, "swap_prep");
    load_all(16384, 16384, 16384, 16384);
    accept(1000, 1'b0, 1'b0, 0, 0, e);
    step();
    step();
    bus.cfg_commit = 1'b1;
    m_pend = 1'b1;
    step();
    bus.cfg_commit = 1'b0;
    chk("swap_pending_rise", bus.cfg_pending, 1);
    bus.cfg_commit = 1'b1;            // repeated commit while pending
    step();
    bus.cfg_commit = 1'b0;
    finish_out(y);
    chk("swap_old_bank", y, e);
    step();
    chk("swap_pending_hold", bus.cfg_pending, 1);
    accept(2000, 1'b0, 1'b0, 0, 0, e);
    chk("swap_pending_fall", bus.cfg_pending, 0);
    finish_out(y);
    chk("swap_new_bank", y, e);
    for (int i = 0; i < 4; i++) begin
      accept(4000, 1'b0, 1'b0, 0, 0, e);
      finish_out(y);
      chk("swap_flush_model", y, e);
    end
    chk("swap_flush_vector", y, 8000);

    // ---- commit and write on the accept edge ----
    write_coeff(1, 4096);
    write_coeff(2, 4096);
    write_coeff(3, 4096);
    accept(16384, 1'b1, 1'b1, 0, -4096, e);
    chk("edge_commit_no_pending", bus.cfg_pending, 0);
    finish_out(y);
    chk("edge_commit_model", y, e);
    chk("edge_commit_vector", y, -548);

    // ---- backpressure ----
    bus.out_ready = 1'b0;
    accept(-7000, 1'b0, 1'b0, 0, 0, e);
    for (int n = 0; n < 20 && !bus.out_valid; n++) step();
    chk("bp_valid", bus.out_valid, 1);
    chk("bp_data", bus.out_data, e);
    hold = bus.out_data;
    for (int j = 0; j < 10; j++) begin
      step();
      chk("bp_valid_hold", bus.out_valid, 1);
      chk("bp_data_hold", bus.out_data, hold);
      chk("bp_in_ready_low", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    step();
    chk("bp_release_valid", bus.out_valid, 0);
    step();
    chk("bp_release_in_ready", bus.in_ready, 1);

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < NT; k++) write_coeff(k, int'($urandom_range(0, 65535)) - 32768);
        commit();
      end
      do_sample(int'($urandom_range(0, 65535)) - 32768, "random_model");
    end

    // ---- reset mid-operation ----
    load_all(8192, 8192, 8192, 8192);
    commit();
    do_sample(20000, "pre_reset");
    accept(12000, 1'b0, 1'b0, 0, 0, e);
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_data", bus.out_data, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    chk("midrst_pending", bus.cfg_pending, 0);
    step();
    step();
    chk("midrst_out_valid_held", bus.out_valid, 0);
    rst = 1'b0;
    model_reset();
    step();
    chk("midrst_in_ready_back", bus.in_ready, 1);
    load_all(1000, 2000, 3000, 4000);
    commit();
    for (int i = 0; i < 4; i++) begin
      accept(imp_tbl[i].din, 1'b0, 1'b0, 0, 0, e);
      finish_out(y);
      chk("postrst_model", y, e);
      chk("postrst_vector", y, imp_tbl[i].expv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
